// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating direction counters.
// Registered prediction one cycle after a PC query; trained by branch-unit resolutions.
module branch_predictor #(
    parameter int ENTRIES = 64,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        query_valid_i,
    input  logic [31:0] query_pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_is_jump_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] q_idx;
    logic [TAG_W-1:0] q_tag;
    logic             q_hit;
    logic             q_taken;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_taken;
    logic [1:0]       u_ctr_cur;
    logic [1:0]       u_ctr_next;

    // Byte-offset bits carry no information for word-aligned PCs.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{query_pc_i[1:0], upd_pc_i[1:0]};

    always_comb begin
        q_idx   = query_pc_i[IDX_W+1:2];
        q_tag   = query_pc_i[31:IDX_W+2];
        q_hit   = valid_q[q_idx] && (tag_q[q_idx] == q_tag);
        q_taken = q_hit && ctr_q[q_idx][1];
    end

    always_comb begin
        u_idx     = upd_pc_i[IDX_W+1:2];
        u_tag     = upd_pc_i[31:IDX_W+2];
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_taken   = upd_taken_i || upd_is_jump_i;
        u_ctr_cur = ctr_q[u_idx];
        if (upd_is_jump_i) begin
            u_ctr_next = 2'b11;
        end else if (u_taken) begin
            u_ctr_next = (u_ctr_cur == 2'b11) ? u_ctr_cur : u_ctr_cur + 2'b01;
        end else begin
            u_ctr_next = (u_ctr_cur == 2'b00) ? u_ctr_cur : u_ctr_cur - 2'b01;
        end
    end

    // Query reads the arrays before this edge's update lands (read-before-write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            pred_valid_o  <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
        end else begin
            pred_valid_o <= query_valid_i;
            if (query_valid_i) begin
                pred_taken_o  <= q_taken;
                pred_target_o <= q_taken ? target_q[q_idx] : query_pc_i + 32'd4;
            end

            if (upd_valid_i) begin
                if (u_hit) begin
                    ctr_q[u_idx] <= u_ctr_next;
                    if (u_taken) begin
                        target_q[u_idx] <= upd_target_i;
                    end
                end else if (u_taken) begin
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= upd_target_i;
                    ctr_q[u_idx]    <= upd_is_jump_i ? 2'b11 : 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected predictions queued at query time,
// popped and checked when the registered prediction appears.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        query_valid_i;
    logic [31:0] query_pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_is_jump_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .query_valid_i (query_valid_i),
        .query_pc_i    (query_pc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_is_jump_i (upd_is_jump_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        v;
        logic        t;
        logic [31:0] tgt;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic        last_t = 1'b0;
    logic [31:0] last_tgt = 32'h0;

    // One clock: drive inputs, queue the expected prediction, check it after the edge.
    task automatic step(input string name, input logic rst,
                        input logic qv, input logic [31:0] qpc,
                        input logic uv, input logic [31:0] upc,
                        input logic uj, input logic ut, input logic [31:0] utgt,
                        input logic et, input logic [31:0] etgt);
        exp_t e;
        exp_t got;
        rst_i         = rst;
        query_valid_i = qv;
        query_pc_i    = qpc;
        upd_valid_i   = uv;
        upd_pc_i      = upc;
        upd_is_jump_i = uj;
        upd_taken_i   = ut;
        upd_target_i  = utgt;
        e.name = name;
        if (rst) begin
            e.v = 1'b0; e.t = 1'b0; e.tgt = 32'h0;
        end else if (qv) begin
            e.v = 1'b1; e.t = et; e.tgt = etgt;
        end else begin
            e.v = 1'b0; e.t = last_t; e.tgt = last_tgt;
        end
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        last_t   = got.t;
        last_tgt = got.tgt;
        tests++;
        assert (pred_valid_o === got.v) else begin
            fails++;
            $error("FAIL %s valid: observed %b expected %b", got.name, pred_valid_o, got.v);
        end
        tests++;
        assert (pred_taken_o === got.t) else begin
            fails++;
            $error("FAIL %s taken: observed %b expected %b", got.name, pred_taken_o, got.t);
        end
        tests++;
        assert (pred_target_o === got.tgt) else begin
            fails++;
            $error("FAIL %s target: observed %h expected %h", got.name, pred_target_o, got.tgt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; query_valid_i = 1'b0; query_pc_i = '0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_is_jump_i = 1'b0;
        upd_taken_i = 1'b0; upd_target_i = '0;
        @(posedge clk_i);
        #1;
        //   name            rst qv  qpc           uv  upc           uj  ut  utgt          et  etgt
        step("reset",        1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
        step("cold_q1000",   0, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h0,        0, 32'h1004);
        step("upd_t_1000",   0, 0, 32'h0,        1, 32'h1000,     0, 1, 32'h1040,     0, 32'h0);
        step("q1000_ctr10",  0, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h0,        1, 32'h1040);
        step("upd_nt_1000",  0, 0, 32'h0,        1, 32'h1000,     0, 0, 32'h0,        0, 32'h0);
        step("q1000_ctr01",  0, 1, 32'h1000,     0, 32'h0,        0, 0, 32'h0,        0, 32'h1004);
        for (int i = 0; i < 4; i++)
            step("upd_t_2000", 0, 0, 32'h0,      1, 32'h2000,     0, 1, 32'h2080,     0, 32'h0);
        step("upd_nt_2000",  0, 0, 32'h0,        1, 32'h2000,     0, 0, 32'h0,        0, 32'h0);
        step("q2000_ctr10",  0, 1, 32'h2000,     0, 32'h0,        0, 0, 32'h0,        1, 32'h2080);
        for (int i = 0; i < 4; i++)
            step("upd_nt_2000", 0, 0, 32'h0,     1, 32'h2000,     0, 0, 32'h0,        0, 32'h0);
        step("upd_t_2000b",  0, 0, 32'h0,        1, 32'h2000,     0, 1, 32'h20c0,     0, 32'h0);
        step("q2000_ctr01",  0, 1, 32'h2000,     0, 32'h0,        0, 0, 32'h0,        0, 32'h2004);
        step("upd_jal_3000", 0, 0, 32'h0,        1, 32'h3000,     1, 1, 32'h0800,     0, 32'h0);
        step("q3000_jal",    0, 1, 32'h3000,     0, 32'h0,        0, 0, 32'h0,        1, 32'h0800);
        step("q3002_lowbits",0, 1, 32'h3002,     0, 32'h0,        0, 0, 32'h0,        1, 32'h0800);
        step("q3100_alias",  0, 1, 32'h3100,     0, 32'h0,        0, 0, 32'h0,        0, 32'h3104);
        step("q4000_rbw",    0, 1, 32'h4000,     1, 32'h4000,     0, 1, 32'h4400,     0, 32'h4004);
        step("q4000_after",  0, 1, 32'h4000,     0, 32'h0,        0, 0, 32'h0,        1, 32'h4400);
        step("idle_hold",    0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
        step("q_fffffffc",   0, 1, 32'hffff_fffc, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0);
        step("rst_mid",      1, 1, 32'h5000,     1, 32'h5000,     0, 1, 32'h5500,     0, 32'h0);
        step("q5000_post",   0, 1, 32'h5000,     0, 32'h0,        0, 0, 32'h0,        0, 32'h5004);
        step("q3000_post",   0, 1, 32'h3000,     0, 32'h0,        0, 0, 32'h0,        0, 32'h3004);
        step("q4000_post",   0, 1, 32'h4000,     0, 32'h0,        0, 0, 32'h0,        0, 32'h4004);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
